// File: rtl/column_wta_inhibit.sv
// column_wta_inhibit
//  One-winner-take-all lateral inhibition over a gamma cycle. The first rising
//  edge seen on in_spikes during a gamma cycle is passed through on out_spikes
//  (one clock later). Every other line stays quiet until the cycle closes. When
//  the cycle closes, {winner, time, none} is offered through a one-entry
//  valid/ready result buffer.
//
//  Optional feature macro: WTA_TIEBREAK_ROTATE_EN
//    undefined : simultaneous edges resolved by fixed priority (lowest index)
//    defined   : round-robin priority; the search starts at prio and wraps, and
//                prio moves to (winner+1)%NEURONS after each cycle that has a winner
//
//  Result handshake: an entry is transferred when result_valid && result_ready
//  are both high on a rising clock edge. result_valid, once high, stays high and
//  the payload stays stable until that transfer happens. A result produced while
//  the buffer is full and not being drained is dropped, and the sticky overflow
//  flag is set.
//
//  Debug: dbg_state exposes the FSM state (0=IDLE, 1=LISTEN, 2=INHIBIT).
module column_wta_inhibit #(
  parameter  int NEURONS   = 4,
  parameter  int GAMMA_LEN = 8,
  localparam int IW        = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int TW        = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gamma_start,
  input  logic [NEURONS-1:0] in_spikes,
  output logic [NEURONS-1:0] out_spikes,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [IW-1:0]      result_winner,
  output logic [TW-1:0]      result_time,
  output logic               result_none,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LISTEN  = 2'd1;
  localparam logic [1:0] S_INHIBIT = 2'd2;

  logic [1:0]         state;
  logic [TW-1:0]      t;
  logic [NEURONS-1:0] prev_in;
  logic [IW-1:0]      cur_winner;
  logic [TW-1:0]      cur_time;

  logic [NEURONS-1:0] edges;
  logic               sel_found;
  logic [IW-1:0]      sel_idx;
  logic [NEURONS-1:0] sel_onehot;

  logic               active;
  logic               last_t;
  logic               close_cycle;
  logic               take_last;
  logic               close_none;
  logic [IW-1:0]      close_winner;
  logic [TW-1:0]      close_time;
  logic               pop;

  assign edges     = in_spikes & ~prev_in;
  assign dbg_state = state;

  assign active      = (state == S_LISTEN) || (state == S_INHIBIT);
  assign last_t      = (t == TW'(GAMMA_LEN - 1));
  assign close_cycle = active && (gamma_start || last_t);

  // An edge sampled on the last tick of LISTEN still wins the closing cycle.
  // An edge sampled together with gamma_start belongs to the next cycle.
  assign take_last    = (state == S_LISTEN) && !gamma_start && sel_found;
  assign close_none   = (state == S_LISTEN) && !take_last;
  assign close_winner = take_last ? sel_idx : (close_none ? '0 : cur_winner);
  assign close_time   = take_last ? t       : (close_none ? '0 : cur_time);

  assign pop = result_valid && result_ready;

`ifdef WTA_TIEBREAK_ROTATE_EN
  logic [IW-1:0] prio;
  logic [IW-1:0] probe;

  // Winner search: round-robin, starting at prio and wrapping around.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    probe      = '0;
    for (int k = 0; k < NEURONS; k++) begin
      probe = IW'((int'(prio) + k) % NEURONS);
      if (!sel_found && edges[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
    for (int i = 0; i < NEURONS; i++) begin
      sel_onehot[i] = sel_found && (sel_idx == IW'(i));
    end
  end

  // Priority pointer: moves past the winner of every cycle that closed with one.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
    end else if (close_cycle && !close_none) begin
      prio <= (close_winner == IW'(NEURONS - 1)) ? '0 : close_winner + IW'(1);
    end
  end
`else
  // Winner search: fixed priority, the lowest index wins.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (!sel_found && edges[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NEURONS; i++) begin
      sel_onehot[i] = sel_found && (sel_idx == IW'(i));
    end
  end
`endif

  // Gamma-cycle FSM, tick counter, edge history and the inhibited output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      t          <= '0;
      prev_in    <= '0;
      cur_winner <= '0;
      cur_time   <= '0;
      out_spikes <= '0;
    end else begin
      prev_in <= gamma_start ? '0 : in_spikes;
      if (close_cycle) begin
        t <= '0;
        if (gamma_start) begin
          // Restart: the next cycle begins on this same clock.
          if (sel_found) begin
            state      <= S_INHIBIT;
            cur_winner <= sel_idx;
            cur_time   <= '0;
            out_spikes <= sel_onehot;
          end else begin
            state      <= S_LISTEN;
            out_spikes <= '0;
          end
        end else begin
          state      <= S_IDLE;
          out_spikes <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (gamma_start) begin
              state <= S_LISTEN;
              t     <= '0;
            end
          end
          S_LISTEN: begin
            t <= t + TW'(1);
            if (sel_found) begin
              state      <= S_INHIBIT;
              cur_winner <= sel_idx;
              cur_time   <= t;
              out_spikes <= sel_onehot;
            end
          end
          S_INHIBIT: begin
            t <= t + TW'(1);
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // One-entry result buffer: load when empty or being drained, else drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid  <= 1'b0;
      result_winner <= '0;
      result_time   <= '0;
      result_none   <= 1'b0;
    end else if (close_cycle && (!result_valid || pop)) begin
      result_valid  <= 1'b1;
      result_winner <= close_winner;
      result_time   <= close_time;
      result_none   <= close_none;
    end else if (pop) begin
      result_valid <= 1'b0;
    end
  end

  // Sticky overflow: a result was lost because the buffer was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (close_cycle && result_valid && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_column_wta_inhibit.sv
// tb_column_wta_inhibit
//  Directed scenarios followed by random traffic. A behavioural model tracks
//  each gamma cycle as "in cycle / tick count / first winner", and it tracks the
//  result buffer as a queue of {none, winner, time} entries.
module tb_column_wta_inhibit;

  localparam int N  = 4;
  localparam int GL = 8;
  localparam int IW = 2;
  localparam int TW = 3;
  localparam int W  = 1 + IW + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          gamma_start = 1'b0;
  logic [N-1:0]  in_spikes = '0;
  logic          result_ready = 1'b0;
  logic [N-1:0]  out_spikes;
  logic          result_valid;
  logic [IW-1:0] result_winner;
  logic [TW-1:0] result_time;
  logic          result_none;
  logic          overflow;
  logic [1:0]    dbg_state;

  column_wta_inhibit #(.NEURONS(N), .GAMMA_LEN(GL)) dut (
    .clk           (clk),
    .rst           (rst),
    .gamma_start   (gamma_start),
    .in_spikes     (in_spikes),
    .out_spikes    (out_spikes),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_winner (result_winner),
    .result_time   (result_time),
    .result_none   (result_none),
    .overflow      (overflow),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  bit           m_in_cycle;
  int           m_t;
  int           m_win;
  int           m_win_t;
  int           m_prio;
  bit           m_ovf;
  logic [N-1:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] e);
    for (int k = 0; k < N; k++) begin
`ifdef WTA_TIEBREAK_ROTATE_EN
      int i = (m_prio + k) % N;
`else
      int i = k;
`endif
      if (e[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic gs, input logic [N-1:0] in, input logic rdy);
    logic [N-1:0] e;
    logic [W-1:0] pv;
    int p;
    bit pop, push, full;
    if (r) begin
      exp_q.delete();
      m_in_cycle = 0; m_t = 0; m_win = -1; m_win_t = 0;
      m_prio = 0; m_ovf = 0; m_prev = '0;
      return;
    end
    e    = in & ~m_prev;
    p    = pick(e);
    full = (exp_q.size() > 0);
    pop  = full && rdy;
    push = 0;
    pv   = '0;
    if (m_in_cycle) begin
      if (m_win < 0 && !gs && p >= 0) begin
        m_win = p; m_win_t = m_t;
      end
      if (gs || m_t == GL - 1) begin
        push = 1;
        if (m_win < 0) pv[W-1] = 1'b1;
        else begin
          pv = {1'b0, IW'(m_win), TW'(m_win_t)};
          m_prio = (m_win + 1) % N;
        end
        m_win = -1; m_t = 0; m_in_cycle = gs;
        if (gs && p >= 0) begin
          m_win = p; m_win_t = 0;
        end
      end else begin
        m_t++;
      end
    end else if (gs) begin
      m_in_cycle = 1; m_t = 0; m_win = -1;
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (!full || pop) exp_q.push_back(pv);
      else m_ovf = 1;
    end
    m_prev = gs ? '0 : in;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic gs, input logic [N-1:0] in, input logic rdy);
    logic [N-1:0] exp_out;
    @(negedge clk);
    rst = r; gamma_start = gs; in_spikes = in; result_ready = rdy;
    model_step(r, gs, in, rdy);
    @(posedge clk);
    #1;
    exp_out = (m_in_cycle && m_win >= 0) ? N'(1 << m_win) : '0;
    chk("out_spikes", 32'(out_spikes), 32'(exp_out));
    chk("result_valid", 32'(result_valid), 32'(exp_q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() > 0) begin
      chk("result_none", 32'(result_none), 32'(exp_q[0][W-1]));
      chk("result_winner", 32'(result_winner), 32'(exp_q[0][IW+TW-1:TW]));
      chk("result_time", 32'(result_time), 32'(exp_q[0][TW-1:0]));
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  // One full gamma cycle: gamma_start, then GL ticks with the pattern raised from spike_t on.
  task automatic run_cycle(input logic [N-1:0] pat, input int spike_t, input logic rdy);
    step(1'b0, 1'b1, '0, rdy);
    for (int k = 0; k < GL; k++) step(1'b0, 1'b0, (k >= spike_t) ? pat : '0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] cur_in;
    logic gs, rdy, r;

    do_reset();
    chk("rst_out", 32'(out_spikes), 32'h0);
    chk("rst_valid", 32'(result_valid), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // single spike on line 2 at t=3
    step(1'b0, 1'b1, '0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 4'b0100, 1'b0);
    chk("t1_out_t4", 32'(out_spikes), 32'h4);
    for (int k = 4; k < GL; k++) step(1'b0, 1'b0, 4'b0100, 1'b0);
    chk("t1_out_closed", 32'(out_spikes), 32'h0);
    chk("t1_valid", 32'(result_valid), 32'h1);
    chk("t1_winner", 32'(result_winner), 32'd2);
    chk("t1_time", 32'(result_time), 32'd3);
    chk("t1_none", 32'(result_none), 32'h0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("t1_popped", 32'(result_valid), 32'h0);

    // tie of lines 1 and 3 at t=2, line 0 later at t=5
    do_reset();
    step(1'b0, 1'b1, '0, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, '0, 1'b0);
    for (int k = 2; k < 5; k++) step(1'b0, 1'b0, 4'b1010, 1'b0);
    for (int k = 5; k < GL; k++) step(1'b0, 1'b0, 4'b1011, 1'b0);
    chk("t2_winner", 32'(result_winner), 32'd1);
    chk("t2_time", 32'(result_time), 32'd2);
    step(1'b0, 1'b0, '0, 1'b1);
    run_cycle(4'b1010, 0, 1'b0);
`ifdef WTA_TIEBREAK_ROTATE_EN
    chk("t2_tie_rot", 32'(result_winner), 32'd3);
`else
    chk("t2_tie_fixed", 32'(result_winner), 32'd1);
`endif
    chk("t2_tie_time", 32'(result_time), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);

    // no spike in a whole cycle
    run_cycle('0, 99, 1'b0);
    chk("t3_none", 32'(result_none), 32'h1);
    chk("t3_winner", 32'(result_winner), 32'h0);
    chk("t3_time", 32'(result_time), 32'h0);
    step(1'b0, 1'b0, '0, 1'b1);

    // overflow: three cycles with the consumer stalled
    run_cycle(4'b0001, 1, 1'b0);
    chk("t4_ovf_first", 32'(overflow), 32'h0);
    run_cycle('0, 99, 1'b0);
    chk("t4_ovf_second", 32'(overflow), 32'h1);
    chk("t4_held_winner", 32'(result_winner), 32'd0);
    chk("t4_held_time", 32'(result_time), 32'd1);
    chk("t4_held_none", 32'(result_none), 32'h0);
    run_cycle('0, 99, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("t4_popped", 32'(result_valid), 32'h0);
    chk("t4_ovf_sticky", 32'(overflow), 32'h1);

    // gamma_start at t=5 while inhibiting (winner 0 at t=1)
    do_reset();
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k < 5; k++) step(1'b0, 1'b0, 4'b0001, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    chk("t5_out_cleared", 32'(out_spikes), 32'h0);
    chk("t5_winner", 32'(result_winner), 32'd0);
    chk("t5_time", 32'(result_time), 32'd1);
    chk("t5_state", 32'(dbg_state), 32'd1);
    for (int k = 0; k < GL; k++) step(1'b0, 1'b0, '0, 1'b1);

    // reset at t=4 after a winner
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0, 4'b0100, 1'b0);
    step(1'b1, 1'b0, 4'b0100, 1'b0);
    chk("t6_out", 32'(out_spikes), 32'h0);
    chk("t6_valid", 32'(result_valid), 32'h0);
    chk("t6_state", 32'(dbg_state), 32'h0);

    // random traffic
    cur_in = '0;
    for (int n = 0; n < 800; n++) begin
      gs  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 199) == 0);
      if (gs && $urandom_range(0, 1) == 1) cur_in = '0;
      else if ($urandom_range(0, 3) == 0) cur_in = cur_in | N'(1 << $urandom_range(0, N - 1));
      else if ($urandom_range(0, 19) == 0) cur_in = N'($urandom_range(0, (1 << N) - 1));
      step(r, gs, cur_in, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
